// File: rtl/echo_client.sv
// echo_client: initiator end of the echo request/indication protocol.
// Issues a burst of start_count requests carrying seed, seed+STEP, ...,
// keeps up to MAX_OUTSTANDING of them in flight and checks every in-order
// indication against the value it is expected to return.
//
// Optional build macro: ECHO_CLIENT_TIMEOUT_EN adds a watchdog that ends a
// burst with timeout=1 when no indication arrives for TIMEOUT_CYCLES
// cycles while requests are outstanding.
//
// Handshake semantics (both channels): a transfer happens in exactly the
// cycle where __ENA and __RDY are both high. echoReq__ENA is only raised
// while echoReq__RDY is high. An ind_echo__ENA seen while ind_echo__RDY is
// low is not a transfer; it is counted as a spurious indication.
module echo_client #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] STEP            = 32'd1
`ifdef ECHO_CLIENT_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        start__RDY,
    input  logic        start__ENA,
    input  logic [15:0] start_count,
    input  logic [31:0] start_seed,
    input  logic        echoReq__RDY,
    output logic        echoReq__ENA,
    output logic [31:0] echoReq_v,
    output logic        ind_echo__RDY,
    input  logic        ind_echo__ENA,
    input  logic [31:0] ind_echo_v,
    output logic        busy,
    output logic        done,
    output logic [15:0] resp_count,
    output logic [15:0] err_count,
`ifdef ECHO_CLIENT_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

`ifdef ECHO_CLIENT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd;
`endif

    state_t      state;
    logic [15:0] count;
    logic [15:0] sent;
    logic [31:0] next_val;
    logic [31:0] exp_val;
    logic [3:0]  outstanding;

    logic fire;
    logic accept;
    logic spurious;
    logic mismatch;

    // Handshake decode: issue and accept conditions for this cycle.
    always_comb begin
        fire     = (state == S_RUN) && (sent < count) &&
                   (outstanding < MAX_OS) && echoReq__RDY;
        ind_echo__RDY = ((state == S_RUN) || (state == S_DRAIN)) &&
                        (outstanding != 4'd0);
        accept   = ind_echo__ENA && ind_echo__RDY;
        spurious = ind_echo__ENA && !ind_echo__RDY;
        mismatch = accept && (ind_echo_v != exp_val);
    end

    assign echoReq__ENA = fire;
    assign echoReq_v    = next_val;
    assign start__RDY   = (state == S_IDLE) || (state == S_DONE);
    assign busy         = (state == S_RUN) || (state == S_DRAIN);
    assign done         = (state == S_DONE);
    assign dbg_state    = state;

    // Burst FSM with its data, credit and response/error counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= S_IDLE;
            count       <= 16'd0;
            sent        <= 16'd0;
            next_val    <= 32'd0;
            exp_val     <= 32'd0;
            outstanding <= 4'd0;
            resp_count  <= 16'd0;
            err_count   <= 16'd0;
`ifdef ECHO_CLIENT_TIMEOUT_EN
            wd          <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            // Mismatches and spurious indications are counted in any state;
            // a start in the same cycle overrides this below.
            if ((mismatch || spurious) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start__ENA) begin
                        count       <= start_count;
                        next_val    <= start_seed;
                        exp_val     <= start_seed;
                        sent        <= 16'd0;
                        resp_count  <= 16'd0;
                        outstanding <= 4'd0;
                        err_count   <= 16'd0;
                        state       <= (start_count == 16'd0) ? S_DONE : S_RUN;
`ifdef ECHO_CLIENT_TIMEOUT_EN
                        wd          <= '0;
                        timeout     <= 1'b0;
`endif
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (fire) begin
                        next_val <= next_val + STEP;
                        sent     <= sent + 16'd1;
                    end
                    if (accept) begin
                        exp_val    <= exp_val + STEP;
                        resp_count <= resp_count + 16'd1;
                    end
                    // Issue and accept in the same cycle cancel out.
                    case ({fire, accept})
                        2'b10:   outstanding <= outstanding + 4'd1;
                        2'b01:   outstanding <= outstanding - 4'd1;
                        default: outstanding <= outstanding;
                    endcase
                    if ((state == S_RUN) && fire && (sent + 16'd1 == count))
                        state <= S_DRAIN;
                    if ((state == S_DRAIN) && accept &&
                        (resp_count + 16'd1 == count))
                        state <= S_DONE;
`ifdef ECHO_CLIENT_TIMEOUT_EN
                    // Watchdog only runs while something is owed to us.
                    if (accept || (outstanding == 4'd0)) begin
                        wd <= '0;
                    end else if (wd == WD_LAST) begin
                        wd          <= '0;
                        timeout     <= 1'b1;
                        outstanding <= 4'd0;
                        state       <= S_DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/echo_client.md
Name: echo_client

Overview:
- Initiator end of the echo request/indication protocol: drives echoReq, consumes ind_echo, and checks each returned value.
- Issues a programmed burst of requests with an arithmetic data sequence and keeps several requests in flight, bounded by a credit limit.
- Compares each in-order response against its expected value and reports response and error counts.
- Sits opposite an echo responder in loopback tests and serves as the traffic generator for bring-up benches.

Parameters:
- MAX_OUTSTANDING, 4: maximum requests in flight (1..15).
- STEP, 1: increment added to the data value after each request; arithmetic mod 2^32.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- start__RDY  out  1  ready to accept start; high in IDLE or DONE.
- start__ENA  in  1  start a burst; acted on only when start__RDY=1.
- start_count  in  16  number of requests in the burst.
- start_seed  in  32  data value of the first request.
- echoReq__RDY  in  1  responder can accept a request.
- echoReq__ENA  out  1  request fires this cycle.
- echoReq_v  out  32  request data.
- ind_echo__RDY  out  1  client accepts an indication.
- ind_echo__ENA  in  1  indication valid.
- ind_echo_v  in  32  indication data.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- resp_count  out  16  responses accepted in the current burst.
- err_count  out  16  mismatches plus spurious indications; saturates at 0xFFFF.

Behaviour:
- Reset:
  - state=IDLE.
  - next_val, exp_val, sent, resp_count, outstanding and err_count all 0.
  - All outputs 0 except start__RDY=1.
  - A reset mid-burst abandons the burst immediately; late indications after reset count as spurious.
- States: IDLE, RUN, DRAIN, DONE.
- Start, on start__ENA & start__RDY:
  - Latch count and seed; next_val=exp_val=seed.
  - Clear sent, resp_count, outstanding and err_count.
  - Next state is RUN, or DONE if count=0.
  - start__ENA while start__RDY=0 is ignored.
- Request issue (echoReq__ENA):
  - Combinational: echoReq__ENA = (state==RUN) & (sent<count) & (outstanding<MAX_OUTSTANDING) & echoReq__RDY.
  - echoReq_v = next_val, always driven.
  - On fire: next_val += STEP, sent++, outstanding++. Zero-cycle latency from echoReq__RDY to ENA.
- Response accept:
  - ind_echo__RDY = (state==RUN | state==DRAIN) & (outstanding>0).
  - On ind_echo__ENA & RDY: compare ind_echo_v with exp_val; on mismatch err_count++.
  - Then exp_val += STEP, resp_count++, outstanding--.
- Spurious indication: ind_echo__ENA with RDY=0 increments err_count and changes no other state.
- Simultaneous issue and accept in one cycle: outstanding is unchanged; both counters update.
- Transitions:
  - RUN -> DRAIN when the last request fires (sent reaches count).
  - DRAIN -> DONE when resp_count reaches count.
  - A single cycle may carry both the last issue and the last accept only when MAX_OUTSTANDING allows it; DONE is still reached only after resp_count==count.
- DONE: holds counts until the next start.
- Counters:
  - outstanding is 4 bits.
  - sent and resp_count are 16 bits and never exceed count.
  - err_count saturates at 0xFFFF.

Optional Feature:
- Macro: ECHO_CLIENT_TIMEOUT_EN.
- When defined:
  - Adds output timeout (1 bit) and a watchdog counter.
  - The watchdog clears on any accepted indication and whenever outstanding=0.
  - It increments each cycle in RUN or DRAIN while outstanding>0.
  - On reaching TIMEOUT_CYCLES: timeout=1, go to DONE, outstanding forced to 0.
  - timeout clears on reset or on the next start.
- When undefined: no port, no counter; the client waits indefinitely.

Test Plan:
- Basic loopback: count=3, seed=0x10, responder echoes 1 cycle after each request -> echoReq_v 0x10,0x11,0x12; resp_count=3, err_count=0, done=1.
- Backpressure: echoReq__RDY low 5 cycles mid-burst -> no echoReq__ENA during those cycles; echoReq_v holds 0x11; burst completes with err_count=0.
- Credit limit: count=8, responder withholds indications -> exactly 4 requests issue, then stall. Release one indication -> exactly one more request next cycle.
- Mismatch and spurious:
  - Responder returns 0x15 for request 0x10 -> err_count=1, resp_count=1, next expected value 0x11.
  - One ind_echo__ENA while IDLE -> err_count increments by 1.
- Zero count and reset: start_count=0 -> DONE the cycle after start, no requests. nRST low after 2 of 5 requests -> IDLE, all counts 0, start__RDY=1.
- Timeout (ECHO_CLIENT_TIMEOUT_EN, TIMEOUT_CYCLES=16): one request never answered -> timeout=1 and done=1 exactly 16 cycles after the last response or issue.
